// File: rtl/control_decode.sv
// MIPS P7 instruction decoder: one-hot per-instruction flags, class flags and a
// sticky reserved-instruction status bit. Flags are combinational from IR.
module control_decode (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR,
    output logic        lb, lbu, lh, lhu, lw,
    output logic        sb, sh, sw,
    output logic        add, addu, sub, subu, slt, sltu, And, Or, Xor, Nor,
    output logic        sll, srl, sra, sllv, srlv, srav,
    output logic        addi, addiu, andi, ori, xori, lui, slti, sltiu,
    output logic        beq, bne, blez, bgtz, bltz, bgez,
    output logic        j, jal, jr, jalr,
    output logic        mult, multu, div, divu, mfhi, mflo, mthi, mtlo,
    output logic        mfc0, mtc0, eret,
    output logic        load,
    output logic        store,
    output logic        regwrite,
    output logic        ri,
    output logic        ri_seen
);

    logic [5:0] opc, funct;
    logic [4:0] rs, rt;

    assign opc   = IR[31:26];
    assign rs    = IR[25:21];
    assign rt    = IR[20:16];
    assign funct = IR[5:0];

    always_comb begin
        {lb, lbu, lh, lhu, lw, sb, sh, sw,
         add, addu, sub, subu, slt, sltu, And, Or, Xor, Nor,
         sll, srl, sra, sllv, srlv, srav,
         addi, addiu, andi, ori, xori, lui, slti, sltiu,
         beq, bne, blez, bgtz, bltz, bgez, j, jal, jr, jalr,
         mult, multu, div, divu, mfhi, mflo, mthi, mtlo,
         mfc0, mtc0, eret} = '0;
        case (opc)
            6'b000000: begin
                case (funct)
                    6'b000000: sll   = 1'b1;
                    6'b000010: srl   = 1'b1;
                    6'b000011: sra   = 1'b1;
                    6'b000100: sllv  = 1'b1;
                    6'b000110: srlv  = 1'b1;
                    6'b000111: srav  = 1'b1;
                    6'b001000: jr    = 1'b1;
                    6'b001001: jalr  = 1'b1;
                    6'b010000: mfhi  = 1'b1;
                    6'b010001: mthi  = 1'b1;
                    6'b010010: mflo  = 1'b1;
                    6'b010011: mtlo  = 1'b1;
                    6'b011000: mult  = 1'b1;
                    6'b011001: multu = 1'b1;
                    6'b011010: div   = 1'b1;
                    6'b011011: divu  = 1'b1;
                    6'b100000: add   = 1'b1;
                    6'b100001: addu  = 1'b1;
                    6'b100010: sub   = 1'b1;
                    6'b100011: subu  = 1'b1;
                    6'b100100: And   = 1'b1;
                    6'b100101: Or    = 1'b1;
                    6'b100110: Xor   = 1'b1;
                    6'b100111: Nor   = 1'b1;
                    6'b101010: slt   = 1'b1;
                    6'b101011: sltu  = 1'b1;
                    default: ;
                endcase
            end
            6'b000001: begin
                if (rt == 5'b00000)      bltz = 1'b1;
                else if (rt == 5'b00001) bgez = 1'b1;
            end
            // eret needs the exact full word; other COP0 forms key on rs only
            6'b010000: begin
                if (IR == 32'h42000018)  eret = 1'b1;
                else if (rs == 5'b00000) mfc0 = 1'b1;
                else if (rs == 5'b00100) mtc0 = 1'b1;
            end
            6'b000010: j     = 1'b1;
            6'b000011: jal   = 1'b1;
            6'b000100: beq   = 1'b1;
            6'b000101: bne   = 1'b1;
            6'b000110: blez  = 1'b1;
            6'b000111: bgtz  = 1'b1;
            6'b001000: addi  = 1'b1;
            6'b001001: addiu = 1'b1;
            6'b001010: slti  = 1'b1;
            6'b001011: sltiu = 1'b1;
            6'b001100: andi  = 1'b1;
            6'b001101: ori   = 1'b1;
            6'b001110: xori  = 1'b1;
            6'b001111: lui   = 1'b1;
            6'b100000: lb    = 1'b1;
            6'b100001: lh    = 1'b1;
            6'b100011: lw    = 1'b1;
            6'b100100: lbu   = 1'b1;
            6'b100101: lhu   = 1'b1;
            6'b101000: sb    = 1'b1;
            6'b101001: sh    = 1'b1;
            6'b101011: sw    = 1'b1;
            default: ;
        endcase
    end

    assign load  = lb | lbu | lh | lhu | lw;
    assign store = sb | sh | sw;

    // Any legal encoding raises exactly one flag, so ri is simply "none raised"
    assign ri = ~|{lb, lbu, lh, lhu, lw, sb, sh, sw,
                   add, addu, sub, subu, slt, sltu, And, Or, Xor, Nor,
                   sll, srl, sra, sllv, srlv, srav,
                   addi, addiu, andi, ori, xori, lui, slti, sltiu,
                   beq, bne, blez, bgtz, bltz, bgez, j, jal, jr, jalr,
                   mult, multu, div, divu, mfhi, mflo, mthi, mtlo,
                   mfc0, mtc0, eret};

    assign regwrite = load | add | addu | sub | subu | slt | sltu
                    | sll | srl | sra | sllv | srlv | srav
                    | And | Or | Xor | Nor
                    | addi | addiu | andi | ori | xori | lui | slti | sltiu
                    | jal | jalr | mflo | mfhi | mfc0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)  ri_seen <= 1'b0;
        else if (ri) ri_seen <= 1'b1;
    end

endmodule

// File: tb/tb_control_decode.sv
// Directed bench for control_decode: flag vector vs hand-computed one-hot,
// class flags, funct sweep and sticky ri_seen behaviour.
module tb_control_decode;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] IR = 32'h0;
    logic lb, lbu, lh, lhu, lw, sb, sh, sw;
    logic add, addu, sub, subu, slt, sltu, And, Or, Xor, Nor;
    logic sll, srl, sra, sllv, srlv, srav;
    logic addi, addiu, andi, ori, xori, lui, slti, sltiu;
    logic beq, bne, blez, bgtz, bltz, bgez, j, jal, jr, jalr;
    logic mult, multu, div, divu, mfhi, mflo, mthi, mtlo;
    logic mfc0, mtc0, eret, load, store, regwrite, ri, ri_seen;

    int total = 0;
    int passed = 0;

    // Bit positions in the flag vector (eret is bit 0, lb is bit 52)
    localparam int ERET=0, MTC0=1, MFC0=2, MTLO=3, MTHI=4, MFLO=5, MFHI=6, DIVU=7,
        DIV=8, MULTU=9, MULT=10, JALR=11, JR=12, JAL=13, J=14, BGEZ=15, BLTZ=16,
        BGTZ=17, BLEZ=18, BNE=19, BEQ=20, SLTIU=21, SLTI=22, LUI=23, XORI=24,
        ORI=25, ANDI=26, ADDIU=27, ADDI=28, SRAV=29, SRLV=30, SLLV=31, SRA=32,
        SRL=33, SLL=34, NOR=35, XOR=36, OR=37, AND=38, SLTU=39, SLT=40, SUBU=41,
        SUB=42, ADDU=43, ADD=44, SW=45, SH=46, SB=47, LW=48, LHU=49, LH=50,
        LBU=51, LB=52, NONE=-1;

    logic [52:0] flags;
    assign flags = {lb, lbu, lh, lhu, lw, sb, sh, sw,
                    add, addu, sub, subu, slt, sltu, And, Or, Xor, Nor,
                    sll, srl, sra, sllv, srlv, srav,
                    addi, addiu, andi, ori, xori, lui, slti, sltiu,
                    beq, bne, blez, bgtz, bltz, bgez, j, jal, jr, jalr,
                    mult, multu, div, divu, mfhi, mflo, mthi, mtlo,
                    mfc0, mtc0, eret};

    control_decode dut (
        .clk(clk), .reset(reset), .IR(IR),
        .lb(lb), .lbu(lbu), .lh(lh), .lhu(lhu), .lw(lw),
        .sb(sb), .sh(sh), .sw(sw),
        .add(add), .addu(addu), .sub(sub), .subu(subu), .slt(slt), .sltu(sltu),
        .And(And), .Or(Or), .Xor(Xor), .Nor(Nor),
        .sll(sll), .srl(srl), .sra(sra), .sllv(sllv), .srlv(srlv), .srav(srav),
        .addi(addi), .addiu(addiu), .andi(andi), .ori(ori), .xori(xori), .lui(lui),
        .slti(slti), .sltiu(sltiu),
        .beq(beq), .bne(bne), .blez(blez), .bgtz(bgtz), .bltz(bltz), .bgez(bgez),
        .j(j), .jal(jal), .jr(jr), .jalr(jalr),
        .mult(mult), .multu(multu), .div(div), .divu(divu),
        .mfhi(mfhi), .mflo(mflo), .mthi(mthi), .mtlo(mtlo),
        .mfc0(mfc0), .mtc0(mtc0), .eret(eret),
        .load(load), .store(store), .regwrite(regwrite), .ri(ri), .ri_seen(ri_seen)
    );

    always #5 clk = ~clk;

    // Expected one-hot from a flag index; NONE gives all zero
    function automatic logic [52:0] onehot(input int idx);
        logic [52:0] v;
        v = '0;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    // {flags, load, store, regwrite, ri} for one IR against hand-derived values
    task automatic dec_case(input string name, input logic [31:0] ir, input int idx,
                            input logic e_load, input logic e_store,
                            input logic e_rw, input logic e_ri);
        logic [56:0] got, exp;
        IR = ir;
        #1;
        got = {flags, load, store, regwrite, ri};
        exp = {onehot(idx), e_load, e_store, e_rw, e_ri};
        total++;
        if (got !== exp)
            $display("FAIL %s IR=%h got=%h expected=%h", name, ir, got, exp);
        else passed++;
    endtask

    task automatic test_reset();
        IR = 32'hFC000000;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (ri_seen !== 1'b0) $display("FAIL reset_hold ri_seen=%b expected 0", ri_seen);
        else passed++;
        @(negedge clk);
        reset = 1'b1;
        IR = 32'h0;
        @(posedge clk); #1;
        total++;
        if (ri_seen !== 1'b0) $display("FAIL reset_release ri_seen=%b expected 0", ri_seen);
        else passed++;
    endtask

    task automatic test_mem();
        dec_case("lw",  32'h8C080004, LW,  1, 0, 1, 0);
        dec_case("lb",  32'h80080004, LB,  1, 0, 1, 0);
        dec_case("lhu", 32'h94080004, LHU, 1, 0, 1, 0);
        dec_case("sw",  32'hAC080004, SW,  0, 1, 0, 0);
        dec_case("sb",  32'hA0080004, SB,  0, 1, 0, 0);
    endtask

    task automatic test_itype();
        dec_case("nop_sll", 32'h00000000, SLL,  0, 0, 1, 0);
        dec_case("slt",     32'h0109502A, SLT,  0, 0, 1, 0);
        dec_case("lui",     32'h3C011234, LUI,  0, 0, 1, 0);
        dec_case("ori",     32'h34211234, ORI,  0, 0, 1, 0);
        dec_case("beq",     32'h11090003, BEQ,  0, 0, 0, 0);
        dec_case("bgtz",    32'h1D000003, BGTZ, 0, 0, 0, 0);
        dec_case("j",       32'h08000010, J,    0, 0, 0, 0);
        dec_case("jal",     32'h0C000010, JAL,  0, 0, 1, 0);
        dec_case("bad_op",  32'hFC000000, NONE, 0, 0, 0, 1);
        dec_case("bad_op2", 32'h5C000000, NONE, 0, 0, 0, 1);
    endtask

    task automatic test_regimm();
        dec_case("bgez",      32'h04010003, BGEZ, 0, 0, 0, 0);
        dec_case("bltz",      32'h04000003, BLTZ, 0, 0, 0, 0);
        dec_case("regimm_ri", 32'h04050003, NONE, 0, 0, 0, 1);
    endtask

    task automatic test_cop0();
        dec_case("eret",      32'h42000018, ERET, 0, 0, 0, 0);
        dec_case("mfc0",      32'h40086000, MFC0, 0, 0, 1, 0);
        dec_case("mtc0",      32'h40886000, MTC0, 0, 0, 0, 0);
        dec_case("eret_near", 32'h42000019, NONE, 0, 0, 0, 1);
        dec_case("cop0_rs1",  32'h40286000, NONE, 0, 0, 0, 1);
    endtask

    task automatic test_sticky();
        @(negedge clk);
        reset = 1'b0;
        #1;
        reset = 1'b1;
        IR = 32'hFC000000;
        #1;
        total++;
        if ({ri, ri_seen} !== 2'b10)
            $display("FAIL sticky_pre ri,ri_seen=%b expected 10", {ri, ri_seen});
        else passed++;
        @(posedge clk); #1;
        total++;
        if (ri_seen !== 1'b1) $display("FAIL sticky_set ri_seen=%b expected 1", ri_seen);
        else passed++;
        IR = 32'h3C011234;
        @(posedge clk); #1;
        total++;
        if ({ri, ri_seen} !== 2'b01)
            $display("FAIL sticky_hold ri,ri_seen=%b expected 01", {ri, ri_seen});
        else passed++;
        #2 reset = 1'b0;
        #1;
        total++;
        if (ri_seen !== 1'b0) $display("FAIL async_clear ri_seen=%b expected 0", ri_seen);
        else passed++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_funct_sweep();
        int idx;
        logic rw;
        for (int f = 0; f < 64; f++) begin
            rw = 1'b1;
            case (f)
                6'o00: idx = SLL;   6'o02: idx = SRL;   6'o03: idx = SRA;
                6'o04: idx = SLLV;  6'o06: idx = SRLV;  6'o07: idx = SRAV;
                6'o10: begin idx = JR;    rw = 1'b0; end
                6'o11: idx = JALR;
                6'o20: idx = MFHI;
                6'o21: begin idx = MTHI;  rw = 1'b0; end
                6'o22: idx = MFLO;
                6'o23: begin idx = MTLO;  rw = 1'b0; end
                6'o30: begin idx = MULT;  rw = 1'b0; end
                6'o31: begin idx = MULTU; rw = 1'b0; end
                6'o32: begin idx = DIV;   rw = 1'b0; end
                6'o33: begin idx = DIVU;  rw = 1'b0; end
                6'o40: idx = ADD;   6'o41: idx = ADDU;  6'o42: idx = SUB;
                6'o43: idx = SUBU;  6'o44: idx = AND;   6'o45: idx = OR;
                6'o46: idx = XOR;   6'o47: idx = NOR;
                6'o52: idx = SLT;   6'o53: idx = SLTU;
                default: begin idx = NONE; rw = 1'b0; end
            endcase
            // rs/rt/rd/shamt bits are arbitrary and must not matter
            dec_case($sformatf("funct_%02h", f), {6'b0, 20'hA5F3C, f[5:0]},
                     idx, 0, 0, rw, (idx == NONE));
        end
    endtask

    initial begin
        test_reset();
        test_mem();
        test_itype();
        test_regimm();
        test_cop0();
        test_sticky();
        test_funct_sweep();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/control_decode.md
Name: control_decode

Overview:
- Instruction decoder for the 5-stage MIPS pipeline (P7 subset incl. CP0).
- Converts a 32-bit instruction word into one-hot per-instruction flags plus grouped class flags.
- Pipeline registers instantiate it to derive write-back, forwarding and hazard controls from their latched IR.
- Flags are combinational; a sticky reserved-instruction status register is clocked.

Parameters:
- none

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset; clears the sticky status register
- IR  input  32  instruction word; opcode=IR[31:26], rs=IR[25:21], rt=IR[20:16], funct=IR[5:0]
- lb, lbu, lh, lhu, lw  output  1 each  load instruction flags
- sb, sh, sw  output  1 each  store instruction flags
- add, addu, sub, subu, slt, sltu, And, Or, Xor, Nor  output  1 each  R-type ALU flags
- sll, srl, sra, sllv, srlv, srav  output  1 each  shift flags
- addi, addiu, andi, ori, xori, lui, slti, sltiu  output  1 each  I-type ALU flags
- beq, bne, blez, bgtz, bltz, bgez  output  1 each  branch flags
- j, jal, jr, jalr  output  1 each  jump flags
- mult, multu, div, divu, mfhi, mflo, mthi, mtlo  output  1 each  HI/LO flags
- mfc0, mtc0, eret  output  1 each  CP0 flags
- load  output  1  OR of the five load flags
- store  output  1  OR of sb, sh, sw
- regwrite  output  1  instruction writes the GPR file
- ri  output  1  IR matches no supported encoding (combinational)
- ri_seen  output  1  sticky registered copy of ri

Behaviour:
- All flags are purely combinational from IR, with zero latency. Exactly one instruction flag is high for a legal IR; all are low when ri=1.
- Opcode decode:
  - lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101
  - sb 101000, sh 101001, sw 101011
  - addi 001000, addiu 001001, slti 001010, sltiu 001011, andi 001100, ori 001101, xori 001110, lui 001111
  - beq 000100, bne 000101, blez 000110, bgtz 000111
  - j 000010, jal 000011
  - REGIMM 000001: rt=00000 gives bltz; rt=00001 gives bgez; any other rt gives ri
- SPECIAL (opcode 000000) funct decode:
  - sll 000000, srl 000010, sra 000011, sllv 000100, srlv 000110, srav 000111
  - jr 001000, jalr 001001
  - mfhi 010000, mthi 010001, mflo 010010, mtlo 010011
  - mult 011000, multu 011001, div 011010, divu 011011
  - add 100000, addu 100001, sub 100010, subu 100011, And 100100, Or 100101, Xor 100110, Nor 100111
  - slt 101010, sltu 101011
  - any other funct gives ri
- COP0 (opcode 010000):
  - rs=00000 gives mfc0; rs=00100 gives mtc0
  - eret only when IR == 32'h42000018
  - anything else gives ri
- No other field checks are made (shamt, and rs/rt on R-type, are ignored). IR=32'h00000000 decodes as sll (nop); ri=0.
- regwrite = load | add | addu | sub | subu | slt | sltu | sll | srl | sra | sllv | srlv | srav | And | Or | Xor | Nor | addi | addiu | andi | ori | xori | lui | slti | sltiu | jal | jalr | mflo | mfhi | mfc0.
- regwrite is low for stores, branches, j, jr, mult/div, mthi/mtlo, mtc0, eret and ri.
- ri_seen register:
  - reset low, at any time: ri_seen goes to 0 immediately, without waiting for a clock edge.
  - While reset is low, ri_seen stays 0 regardless of clk.
  - On posedge clk with reset high: ri_seen <= ri_seen | ri. Once set, it holds until the next reset.
- Changes on IR propagate to the flags in the same cycle. Flags are unaffected by reset.

Test Plan:
- IR=32'h8C080004 (lw) -> lw=1, load=1, regwrite=1, store=0, ri=0, all other flags 0.
- IR=32'h00000000 -> sll=1, regwrite=1, ri=0; then IR=32'h0109502A -> slt=1, regwrite=1.
- IR=32'h04010003 -> bgez=1, regwrite=0; IR=32'h04000003 -> bltz=1; IR=32'h04050003 -> ri=1, all instruction flags 0.
- IR=32'h42000018 -> eret=1, regwrite=0; IR=32'h40086000 -> mfc0=1, regwrite=1; IR=32'h40886000 -> mtc0=1, regwrite=0.
- IR=32'hFC000000 held across a posedge -> ri=1 at once, ri_seen=1 after the edge. Then IR=32'h3C011234 (lui) -> ri=0, ri_seen stays 1. Pulse reset low mid-cycle -> ri_seen=0 with no clock edge.
- Sweep all 64 SPECIAL funct codes with opcode 0 -> each listed funct asserts exactly its flag; the unlisted codes (e.g. 000001, 001010, 111111) assert ri only.
